stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Time-keeping core of the stopwatch. Holds MM:SS as four BCD digits and feeds the 7-segment display block directly. It uses the digit ports min_l, min_r, sec_l and sec_r, 5 bits each.
- Counts up at 1 Hz in run mode, and supports pause/resume and clear.
- In adjust mode, normal counting stops. The selected field (minutes or seconds) then advances at the faster adjust-tick rate.

Parameters:
- MIN_MAX, 59: highest minutes value before wrap to 0. Legal range 1..99.
- SEC_MAX, 59: highest seconds value before wrap to 0. Legal range 1..99.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick_1hz  input  1  single-cycle count enable, once per second.
- tick_adj  input  1  single-cycle adjust-rate enable, 2 Hz.
- pause  input  1  single-cycle pulse, already debounced; toggles run/paused.
- clear  input  1  single-cycle pulse, already debounced; zeroes the time.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; 0 = adjust minutes, 1 = adjust seconds.
- min_l  output  5  minutes tens digit, 0..9, registered.
- min_r  output  5  minutes units digit, 0..9, registered.
- sec_l  output  5  seconds tens digit, 0..9, registered.
- sec_r  output  5  seconds units digit, 0..9, registered.
- running  output  1  1 while in RUN state, registered.

Behaviour:
Reset:
- The reset is asynchronous and active-low.
- While rst_n=0: all digit outputs are 0, running=0, and the state is PAUSED.
- Reset released mid-operation restarts from 00:00 PAUSED. No pending event survives reset.

State machine (two states: PAUSED, RUN):
- A pause pulse toggles the state on that clk edge. running reflects the state.

Priority within one cycle, highest first:
1. clear
2. adjust increment
3. run increment

Clear:
- Digits go to 00:00 on the edge where clear=1.
- A pause pulse in the same cycle still toggles the state.
- All ticks in that cycle are ignored.

Run increment:
- Condition: state RUN, adj=0, tick_1hz=1.
- Seconds increment by one. sec_r wraps 9→0 with a carry into sec_l.
- When seconds equal SEC_MAX, they go to 0 and minutes increment.
- When minutes equal MIN_MAX and seconds equal SEC_MAX, the time wraps to 00:00 and stays in RUN.

Adjust mode (adj=1):
- tick_1hz is ignored in both states.
- On tick_adj=1: sel=0 increments minutes, wrapping MIN_MAX→0; sel=1 increments seconds, wrapping SEC_MAX→0.
- An adjust increment never carries into the other field.
- Adjust works in both PAUSED and RUN. The run/paused state is unchanged by adj transitions.
- When adj falls, counting resumes from the adjusted value if the state is RUN.

Simultaneous events:
- tick_1hz and tick_adj together with adj=0: tick_adj is ignored.
- pause in the same cycle as tick_1hz: the increment uses the state before the toggle. RUN+pause+tick therefore increments and then pauses; PAUSED+pause+tick does not increment.

Arithmetic and latency:
- Internally the block holds 4-bit BCD digits. Output bit 4 is always 0.
- Digit values above 9 are unreachable.
- Latency: outputs change on the clk edge that samples the enabling pulse and are visible the following cycle. There is no combinational path from inputs to outputs.

Test Plan:
- Reset/run: assert rst_n=0, release, then pause pulse, then 75 tick_1hz pulses → running=1 and digits 0,1,1,5 (01:15). Asserting rst_n mid-count immediately gives 00:00, running=0.
- Carry and wrap: preset 59:58 via adjust, RUN, 2 tick_1hz → 00:00 with running=1. Preset 09:59, 1 tick → 10:00 (min_l=1, min_r=0).
- Pause: in RUN at 00:05, pause pulse, 10 tick_1hz → stays 00:05, running=0. A second pause plus 1 tick gives 00:06.
- Adjust: adj=1, sel=0, 61 tick_adj from 00:00 → 01:00 (wrap past 59 without touching seconds). sel=1, 60 tick_adj → seconds wrap to 00 and minutes stay at 01. tick_1hz during adj has no effect.
- Simultaneous events: clear and pause in the same cycle from RUN 12:34 → 00:00, running=0. RUN 00:09 with pause and tick_1hz in the same cycle → 00:10, running=0.
- Non-default parameters MIN_MAX=1, SEC_MAX=3: RUN from 00:00, 8 ticks → sequence 00:01..00:03, 01:00..01:03, 00:00.

Source files
------------

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four BCD digits with run/pause/clear and a per-field adjust mode.
// Clear has the highest priority, then the adjust increment, then the run increment.
module stopwatch_counter #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_adj,
  input  logic       pause,
  input  logic       clear,
  input  logic       adj,
  input  logic       sel,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running
);

  typedef enum logic {PAUSED = 1'b0, RUN = 1'b1} state_t;

  // Wrap limits as two packed BCD digits {tens, units}.
  localparam logic [7:0] MIN_LIM = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0] SEC_LIM = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

  state_t     state_q, state_d;
  logic [7:0] minBcd_q, minBcd_d;
  logic [7:0] secBcd_q, secBcd_d;
  logic       secAtLimit;

  function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  assign secAtLimit = (secBcd_q == SEC_LIM);

  always_comb begin
    state_d  = state_q;
    minBcd_d = minBcd_q;
    secBcd_d = secBcd_q;

    if (pause)
      state_d = (state_q == RUN) ? PAUSED : RUN;

    // The increment decision uses the state before any toggle in this cycle.
    if (clear) begin
      minBcd_d = 8'h00;
      secBcd_d = 8'h00;
    end else if (adj) begin
      if (tick_adj) begin
        if (sel)
          secBcd_d = bcdInc(secBcd_q, SEC_LIM);
        else
          minBcd_d = bcdInc(minBcd_q, MIN_LIM);
      end
    end else if (state_q == RUN && tick_1hz) begin
      secBcd_d = bcdInc(secBcd_q, SEC_LIM);
      if (secAtLimit)
        minBcd_d = bcdInc(minBcd_q, MIN_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PAUSED;
      minBcd_q <= 8'h00;
      secBcd_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      minBcd_q <= minBcd_d;
      secBcd_q <= secBcd_d;
    end
  end

  assign min_l   = {1'b0, minBcd_q[7:4]};
  assign min_r   = {1'b0, minBcd_q[3:0]};
  assign sec_l   = {1'b0, secBcd_q[7:4]};
  assign sec_r   = {1'b0, secBcd_q[3:0]};
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: default-limit and small-limit instances driven in parallel,
// compared every cycle against an integer minutes/seconds model plus directed spot checks.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_adj = 1'b0, pause = 1'b0, clear = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [4:0] minL0, minR0, secL0, secR0, minL1, minR1, secL1, secR1;
  logic running0, running1;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: index 0 = default limits, index 1 = MIN_MAX=1, SEC_MAX=3.
  int mMin[2];
  int mSec[2];
  int mMinMax[2] = '{59, 1};
  int mSecMax[2] = '{59, 3};
  bit mRun;

  always #5 clk = ~clk;

  stopwatch_counter dut0 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .pause(pause),
    .clear(clear), .adj(adj), .sel(sel), .min_l(minL0), .min_r(minR0), .sec_l(secL0),
    .sec_r(secR0), .running(running0)
  );

  stopwatch_counter #(.MIN_MAX(1), .SEC_MAX(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .pause(pause),
    .clear(clear), .adj(adj), .sel(sel), .min_l(minL1), .min_r(minR1), .sec_l(secL1),
    .sec_r(secR1), .running(running1)
  );

  function automatic logic [20:0] packTime(bit r, int m, int s);
    return {r, 5'(m / 10), 5'(m % 10), 5'(s / 10), 5'(s % 10)};
  endfunction

  function automatic logic [20:0] obs0();
    return {running0, minL0, minR0, secL0, secR0};
  endfunction

  function automatic logic [20:0] obs1();
    return {running1, minL1, minR1, secL1, secR1};
  endfunction

  task automatic checkOutput(input string tag, input logic [20:0] observed, input logic [20:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got run=%0b %0d%0d:%0d%0d, expected run=%0b %0d%0d:%0d%0d", tag,
               observed[20], observed[19:15], observed[14:10], observed[9:5], observed[4:0],
               expected[20], expected[19:15], expected[14:10], expected[9:5], expected[4:0]);
    end
  endtask

  task automatic modelReset();
    mRun = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mMin[k] = 0;
      mSec[k] = 0;
    end
  endtask

  task automatic modelStep(input bit t1, input bit ta, input bit p, input bit c, input bit a, input bit s);
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        mMin[k] = 0;
        mSec[k] = 0;
      end else if (a) begin
        if (ta && s) mSec[k] = (mSec[k] == mSecMax[k]) ? 0 : mSec[k] + 1;
        else if (ta) mMin[k] = (mMin[k] == mMinMax[k]) ? 0 : mMin[k] + 1;
      end else if (mRun && t1) begin
        mSec[k]++;
        if (mSec[k] > mSecMax[k]) begin
          mSec[k] = 0;
          mMin[k]++;
          if (mMin[k] > mMinMax[k]) mMin[k] = 0;
        end
      end
    end
    if (p) mRun = !mRun;
  endtask

  task automatic applyStimulus(input bit t1, input bit ta, input bit p, input bit c, input bit a, input bit s);
    @(negedge clk);
    tick_1hz = t1; tick_adj = ta; pause = p; clear = c; adj = a; sel = s;
    @(posedge clk);
    modelStep(t1, ta, p, c, a, s);
    #1;
    checkOutput("cycle0", obs0(), packTime(mRun, mMin[0], mSec[0]));
    checkOutput("cycle1", obs1(), packTime(mRun, mMin[1], mSec[1]));
  endtask

  task automatic doReset();
    @(negedge clk);
    tick_1hz = 0; tick_adj = 0; pause = 0; clear = 0; adj = 0; sel = 0;
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset0", obs0(), 21'd0);
    checkOutput("reset1", obs1(), 21'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  task automatic adjustTo(input int m, input int s);
    for (int i = 0; i < m; i++) applyStimulus(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < s; i++) applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  logic [7:0] smallSeq[8] = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00};

  initial begin
    modelReset();
    doReset();

    // Basic counting from reset, then an asynchronous reset mid-count.
    applyStimulus(0, 0, 1, 0, 0, 0);
    runTicks(75);
    checkOutput("run75", obs0(), packTime(1, 1, 15));
    runTicks(3);
    doReset();

    // Carry and full wrap.
    adjustTo(59, 58);
    applyStimulus(0, 0, 1, 0, 0, 0);
    runTicks(2);
    checkOutput("wrap5959", obs0(), packTime(1, 0, 0));
    applyStimulus(0, 0, 0, 1, 0, 0);
    adjustTo(9, 59);
    runTicks(1);
    checkOutput("carry0959", obs0(), packTime(1, 10, 0));

    // Pause holds the count.
    applyStimulus(0, 0, 0, 1, 0, 0);
    runTicks(5);
    applyStimulus(0, 0, 1, 0, 0, 0);
    runTicks(10);
    checkOutput("pausedHold", obs0(), packTime(0, 0, 5));
    applyStimulus(0, 0, 1, 0, 0, 0);
    runTicks(1);
    checkOutput("resume", obs0(), packTime(1, 0, 6));

    // Adjust wraps within its field only; tick_1hz ignored meanwhile.
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 61; i++) applyStimulus(i % 2, 1, 0, 0, 1, 0);
    checkOutput("adjMin61", obs0(), packTime(1, 1, 0));
    for (int i = 0; i < 60; i++) applyStimulus(1, 1, 0, 0, 1, 1);
    checkOutput("adjSec60", obs0(), packTime(1, 1, 0));
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("adjNo1hz", obs0(), packTime(1, 1, 0));

    // Simultaneous events.
    applyStimulus(0, 0, 0, 1, 0, 0);
    adjustTo(12, 34);
    applyStimulus(1, 1, 1, 1, 0, 0);
    checkOutput("clearPause", obs0(), packTime(0, 0, 0));
    applyStimulus(0, 0, 1, 0, 0, 0);
    runTicks(9);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("tickPause", obs0(), packTime(0, 0, 10));
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("pausedTick", obs0(), packTime(1, 0, 10));

    // Small-limit instance sequence.
    doReset();
    applyStimulus(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      runTicks(1);
      checkOutput("smallSeq", obs1(), {1'b1, 5'd0, 1'b0, smallSeq[i][7:4], 5'd0, 1'b0, smallSeq[i][3:0]});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit t1, ta, p, c, a, s;
      if ($urandom_range(0, 399) == 0) doReset();
      t1 = ($urandom_range(0, 1) == 1);
      ta = ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 29) == 0);
      c  = ($urandom_range(0, 79) == 0);
      a  = ($urandom_range(0, 9) < 3) ? !adj : adj;
      s  = ($urandom_range(0, 19) == 0) ? !sel : sel;
      applyStimulus(t1, ta, p, c, a, s);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
